pipe_hazard_ctrl: RTL
=====================

// Module: pipe_hazard_ctrl
// PURPOSE
//  Stall/flush sequencer for the 5-stage pipeline registers (PC, IF_ID, ID_EX, EX_MEM, MEM_WB).
//  Detects load-use hazards, taken-branch redirects, data-memory wait and multi-cycle divide.
//  Drives per-register enable/flush; each register loads when en=1, loads NOP/zeros when flush=1.
//  Also keeps saturating stall/flush performance counters.
// PARAMETERS
//  DIV_CYCLES  16  total cycles a divide occupies EX (>=2)
//  CNT_W       32  width of performance counters
// PORTS
//  clk           in   1      clock, rising edge
//  rst           in   1      reset, asynchronous, active-low
//  id_rs         in   15     ID-stage reg fields {rk,rj,rd} = inst[14:0]
//  id_use_rj     in   1      ID instruction reads rj
//  id_use_rk     in   1      ID instruction reads rk (or rd as source for store/branch)
//  ex_rd         in   5      EX-stage destination register
//  ex_mem_read   in   1      EX instruction is a load
//  ex_div_start  in   1      EX instruction is div/mod (valid in RUN only)
//  br_taken      in   1      EX resolves a taken branch/jump; held stable while EX frozen
//  mem_req       in   1      MEM stage has a data-memory access outstanding
//  mem_ack       in   1      data memory completes access this cycle
//  pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en  out 1 each  register load enables
//  if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush out 1 each  bubble insert
//  div_busy      out  1      FSM in DIV state
//  stall_cnt     out  CNT_W  cycles with pc_en=0, saturating
//  flush_cnt     out  CNT_W  taken-branch flush events, saturating
// BEHAVIOUR
//  Reset (rst=0, async): state=RUN, div counter=0, stall_cnt=0, flush_cnt=0, div_busy=0.
//  Enables/flushes are combinational from state+inputs; all registered state on posedge clk.
//  FSM states: RUN, DIV. RUN->DIV when ex_div_start & ~mem_stall; counter loads DIV_CYCLES-2.
//   DIV: counter decrements when ~mem_stall; DIV->RUN on cycle counter==0 & ~mem_stall
//   (EX advances that cycle). ex_div_start ignored in DIV.
//  mem_stall = mem_req & ~mem_ack. Priority, highest first:
//   1 mem_stall: all *_en=0 except mem_wb_en=1; mem_wb_flush=1. FSM/counter frozen.
//   2 DIV state: pc/if_id/id_ex_en=0; ex_mem_en=1, ex_mem_flush=1; mem_wb_en=1.
//   3 br_taken: all en=1; if_id_flush=1, id_ex_flush=1 (2 wrong-path slots killed).
//   4 load_use: pc_en=0, if_id_en=0; id_ex_en=1, id_ex_flush=1; rest en=1. One bubble.
//   5 none: all en=1, all flush=0.
//  load_use = ex_mem_read & ex_rd!=0 & ((id_use_rj & id_rs[9:5]==ex_rd) | (id_use_rk & id_rs[14:10]==ex_rd)).
//  br_taken and load_use together: branch wins, no bubble (ID instruction is wrong-path).
//  flush never asserted on a register whose en=0; flush only meaningful with en=1.
//  stall_cnt +1 each cycle pc_en=0; flush_cnt +1 each cycle rule 3 applies; both hold at all-ones.
//  Reset mid-divide: FSM returns to RUN immediately; the divide is abandoned.
// STRUCTURE
//  CPU_Parameter.vh: `WORD, `PC_RST, FSM state encodings (`HZ_RUN, `HZ_DIV), reg-field slice macros.
//  One sub-module: sat_counter (param W; inc, async active-low clear) instantiated for stall_cnt/flush_cnt.
// TESTING
//  Reset: drive rst=0 mid-run -> all en=1, flushes=0, div_busy=0, counters 0 without clock edge.
//  Load-use: ex_mem_read=1, ex_rd=5, id_rs[9:5]=5, id_use_rj=1 -> 1 cycle pc_en=0, id_ex_flush=1; stall_cnt=1.
//  ex_rd=0 with matching rj=0 -> no stall; load with id_use_rj=0 -> no stall.
//  Branch: br_taken=1 one cycle -> if_id_flush=id_ex_flush=1, flush_cnt=1; with concurrent load_use -> no stall.
//  Divide DIV_CYCLES=16: ex_div_start pulse -> pc_en=0 for exactly 15 cycles, ex_mem_flush during them, div_busy back to 0.
//  mem_req=1, mem_ack=0 for 3 cycles inside a divide -> full freeze, mem_wb_flush=1; divide extends to 18 stall cycles.
//  Saturation: preload/force stall_cnt to all-ones -> stays all-ones on further stalls.

Source files
------------

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and helpers for the pipeline hazard controller: FSM states
// and instruction register-field slicing.
package pipe_hazard_ctrl_pkg;

  localparam int unsigned WORD   = 32;
  localparam logic [31:0] PC_RST = 32'h1c00_0000;

  typedef enum logic [0:0] {
    HZ_RUN = 1'b0,
    HZ_DIV = 1'b1
  } hz_state_e;

  function automatic logic [4:0] rd_of(input logic [14:0] rs);
    return rs[4:0];
  endfunction

  function automatic logic [4:0] rj_of(input logic [14:0] rs);
    return rs[9:5];
  endfunction

  function automatic logic [4:0] rk_of(input logic [14:0] rs);
    return rs[14:10];
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// Saturating up-counter with asynchronous active-low clear; holds at all-ones.
module sat_counter #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use, branch redirect,
// data-memory wait and multi-cycle divide, plus stall/flush perf counters.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int unsigned DIV_CYCLES = 16,
  parameter int unsigned CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [14:0]      id_rs,
  input  logic             id_use_rj,
  input  logic             id_use_rk,
  input  logic [4:0]       ex_rd,
  input  logic             ex_mem_read,
  input  logic             ex_div_start,
  input  logic             br_taken,
  input  logic             mem_req,
  input  logic             mem_ack,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             id_ex_en,
  output logic             ex_mem_en,
  output logic             mem_wb_en,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             ex_mem_flush,
  output logic             mem_wb_flush,
  output logic             div_busy,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int unsigned DW = (DIV_CYCLES > 2) ? $clog2(DIV_CYCLES - 1) : 1;

  hz_state_e       state;
  logic [DW-1:0]   div_cnt;
  logic            mem_stall;
  logic            load_use;
  logic            br_flush;
  logic            unused_rd;

  assign unused_rd = ^rd_of(id_rs);
  assign mem_stall = mem_req & ~mem_ack;
  assign load_use  = ex_mem_read && (ex_rd != 5'd0) &&
                     ((id_use_rj && (rj_of(id_rs) == ex_rd)) ||
                      (id_use_rk && (rk_of(id_rs) == ex_rd)));
  assign br_flush  = ~mem_stall && (state == HZ_RUN) && br_taken;
  assign div_busy  = (state == HZ_DIV);

  always_comb begin
    pc_en        = 1'b1;
    if_id_en     = 1'b1;
    id_ex_en     = 1'b1;
    ex_mem_en    = 1'b1;
    mem_wb_en    = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    mem_wb_flush = 1'b0;
    if (mem_stall) begin
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      id_ex_en     = 1'b0;
      ex_mem_en    = 1'b0;
      mem_wb_flush = 1'b1;
    end else if (state == HZ_DIV) begin
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      id_ex_en     = 1'b0;
      ex_mem_flush = 1'b1;
    end else if (br_taken) begin
      // Branch outranks load-use: the ID instruction is wrong-path anyway.
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (load_use) begin
      pc_en       = 1'b0;
      if_id_en    = 1'b0;
      id_ex_flush = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= HZ_RUN;
      div_cnt <= '0;
    end else if (!mem_stall) begin
      case (state)
        HZ_RUN: begin
          if (ex_div_start) begin
            state   <= HZ_DIV;
            div_cnt <= DW'(DIV_CYCLES - 2);
          end
        end
        HZ_DIV: begin
          if (div_cnt == '0) begin
            state <= HZ_RUN;
          end else begin
            div_cnt <= div_cnt - 1'b1;
          end
        end
        default: state <= HZ_RUN;
      endcase
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .clr (rst),
    .inc (~pc_en),
    .cnt (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk (clk),
    .clr (rst),
    .inc (br_flush),
    .cnt (flush_cnt)
  );

endmodule
